// File: rtl/mig_tt_evaluator.sv
// mig_tt_evaluator: evaluates a streamed 4-input majority-inverter graph and returns the output truth table.
// Define MIG_TT_ERR_CHECK_EN to enable fanin-index and table-overflow error checking.
module mig_tt_evaluator #(
  parameter int  MAX_NODES = 16,
  parameter int  IDX_W     = 5,
  localparam int CNT_W     = $clog2(MAX_NODES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_a,
  input  logic [IDX_W-1:0] in_b,
  input  logic [IDX_W-1:0] in_c,
  input  logic             in_a_neg,
  input  logic             in_b_neg,
  input  logic             in_c_neg,
  input  logic             in_last,
  input  logic             in_out_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_tt,
  output logic [CNT_W-1:0] out_nodes,
  output logic             out_err
);

  localparam int AW = $clog2(MAX_NODES);

  typedef enum logic {S_ACCEPT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_table [MAX_NODES];
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [15:0]      r_outTt;
  logic [CNT_W-1:0] r_outNodes;
  logic             r_outErr;

  logic [IDX_W-1:0] w_idx [3];
  logic [IDX_W-1:0] w_off [3];
  logic [15:0]      w_op  [3];
  logic [2:0]       w_neg;
  logic [2:0]       w_oob;
  logic [15:0]      w_node;
  logic             w_inXfer;
  logic             w_outXfer;
  logic             w_ovf;
  logic             w_wr;
  logic             w_errNow;
  logic             w_errFinal;

  assign w_idx[0] = in_a;
  assign w_idx[1] = in_b;
  assign w_idx[2] = in_c;
  assign w_neg    = {in_c_neg, in_b_neg, in_a_neg};

  // References to nodes not yet written resolve to constant 0 so results stay deterministic.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_off[i] = w_idx[i] - IDX_W'(5);
      w_oob[i] = (int'(w_idx[i]) >= 5 + int'(r_cnt));
      case (w_idx[i])
        IDX_W'(0): w_op[i] = 16'h0000;
        IDX_W'(1): w_op[i] = 16'hAAAA;
        IDX_W'(2): w_op[i] = 16'hCCCC;
        IDX_W'(3): w_op[i] = 16'hF0F0;
        IDX_W'(4): w_op[i] = 16'hFF00;
        default:   w_op[i] = w_oob[i] ? 16'h0000 : r_table[w_off[i][AW-1:0]];
      endcase
      w_op[i] = w_op[i] ^ {16{w_neg[i]}};
    end
  end

  assign w_node    = (w_op[0] & w_op[1]) | (w_op[0] & w_op[2]) | (w_op[1] & w_op[2]);
  assign w_inXfer  = in_valid && in_ready;
  assign w_outXfer = out_valid && out_ready;
  assign w_ovf     = !in_last && (r_cnt == CNT_W'(MAX_NODES - 1));
  assign w_wr      = w_inXfer && !w_ovf;

`ifdef MIG_TT_ERR_CHECK_EN
  assign w_errNow = w_inXfer && ((|w_oob) || w_ovf);
`else
  assign w_errNow = 1'b0;
`endif

  assign w_errFinal = r_err || w_errNow;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_table[r_cnt[AW-1:0]] <= w_node;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_outTt    <= 16'h0000;
      r_outNodes <= '0;
      r_outErr   <= 1'b0;
    end else if (w_outXfer) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_errNow) begin
        r_err <= 1'b1;
      end
      if (w_inXfer && in_last) begin
        r_outTt    <= w_errFinal ? 16'h0000 : (w_node ^ {16{in_out_neg}});
        r_outNodes <= r_cnt + 1'b1;
        r_outErr   <= w_errFinal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACCEPT;
    end else begin
      r_state <= w_next;
    end
  end

  // in_ready is masked by rst so nothing is offered while reset is held.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        in_ready = !rst;
        if (in_valid && !rst && in_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_ACCEPT;
        end
      end
      default: w_next = S_ACCEPT;
    endcase
  end

  assign out_tt    = r_outTt;
  assign out_nodes = r_outNodes;
  assign out_err   = r_outErr;

endmodule

// File: tb/tb_mig_tt_evaluator.sv
// tb_mig_tt_evaluator: directed self-checking bench for mig_tt_evaluator.
// Expectations follow MIG_TT_ERR_CHECK_EN when the macro is defined for the build.
module tb_mig_tt_evaluator;

  localparam int MAX_NODES = 16;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = $clog2(MAX_NODES + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_a;
  logic [IDX_W-1:0] in_b;
  logic [IDX_W-1:0] in_c;
  logic             in_a_neg;
  logic             in_b_neg;
  logic             in_c_neg;
  logic             in_last;
  logic             in_out_neg;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_tt;
  logic [CNT_W-1:0] out_nodes;
  logic             out_err;

  int testCount = 0;
  int failCount = 0;

  mig_tt_evaluator #(.MAX_NODES(MAX_NODES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_a_neg(in_a_neg), .in_b_neg(in_b_neg), .in_c_neg(in_c_neg),
    .in_last(in_last), .in_out_neg(in_out_neg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tt(out_tt), .out_nodes(out_nodes), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one descriptor for exactly one clock edge; called at posedge+1.
  task automatic applyStimulus(input logic [IDX_W-1:0] a, input logic an,
                               input logic [IDX_W-1:0] b, input logic bn,
                               input logic [IDX_W-1:0] c, input logic cn,
                               input logic last, input logic oneg);
    in_a = a; in_a_neg = an;
    in_b = b; in_b_neg = bn;
    in_c = c; in_c_neg = cn;
    in_last = last; in_out_neg = oneg;
    in_valid = 1'b1;
    checkOutput("in_ready_at_send", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_out_neg = 1'b0;
  endtask

  task automatic takeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, out_valid, 0);
    checkOutput({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic sixProgram(input string tag);
    applyStimulus(5'd0, 1, 5'd3, 0, 5'd4, 0, 0, 0);
    applyStimulus(5'd1, 1, 5'd2, 0, 5'd5, 0, 0, 0);
    applyStimulus(5'd1, 0, 5'd2, 0, 5'd5, 0, 0, 0);
    applyStimulus(5'd1, 0, 5'd6, 0, 5'd7, 1, 0, 0);
    applyStimulus(5'd0, 0, 5'd4, 1, 5'd7, 0, 0, 0);
    checkOutput({tag, "_valid_early"}, out_valid, 0);
    applyStimulus(5'd3, 0, 5'd8, 0, 5'd9, 1, 1, 1);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_tt"}, out_tt, 32'h0669);
    checkOutput({tag, "_nodes"}, out_nodes, 6);
    checkOutput({tag, "_err"}, out_err, 0);
    checkOutput({tag, "_ready_done"}, in_ready, 0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    in_a_neg = 1'b0; in_b_neg = 1'b0; in_c_neg = 1'b0;
    in_last = 1'b0; in_out_neg = 1'b0; out_ready = 1'b0;

    #3;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_tt", out_tt, 0);
    checkOutput("rst_out_nodes", out_nodes, 0);
    checkOutput("rst_out_err", out_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);

    sixProgram("six");
    takeResult("six");

    // Single node held in DONE with a competing descriptor that must not be accepted.
    applyStimulus(5'd1, 0, 5'd2, 0, 5'd0, 0, 1, 0);
    checkOutput("single_tt", out_tt, 32'h8888);
    checkOutput("single_nodes", out_nodes, 1);
    in_a = 5'd3; in_b = 5'd4; in_c = 5'd0; in_valid = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_ready", in_ready, 0);
      checkOutput("hold_tt", out_tt, 32'h8888);
      checkOutput("hold_nodes", out_nodes, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checkOutput("hold_release_valid", out_valid, 0);

    applyStimulus(5'd1, 0, 5'd2, 0, 5'd0, 0, 1, 1);
    checkOutput("single_neg_tt", out_tt, 32'h7777);
    checkOutput("single_neg_nodes", out_nodes, 1);
    takeResult("single_neg");

    applyStimulus(5'd5, 0, 5'd1, 0, 5'd2, 0, 1, 0);
    checkOutput("fwd_valid", out_valid, 1);
    checkOutput("fwd_nodes", out_nodes, 1);
`ifdef MIG_TT_ERR_CHECK_EN
    checkOutput("fwd_err", out_err, 1);
    checkOutput("fwd_tt", out_tt, 0);
`else
    checkOutput("fwd_err", out_err, 0);
    checkOutput("fwd_tt", out_tt, 32'h8888);
`endif
    takeResult("fwd");

    for (int k = 0; k < MAX_NODES + 1; k++) begin
      applyStimulus(5'd1, 0, 5'd2, 0, 5'd0, 0, 0, 0);
    end
    checkOutput("ovf_valid_early", out_valid, 0);
    applyStimulus(5'd1, 0, 5'd2, 0, 5'd0, 0, 1, 0);
    checkOutput("ovf_valid", out_valid, 1);
    checkOutput("ovf_nodes", out_nodes, MAX_NODES);
`ifdef MIG_TT_ERR_CHECK_EN
    checkOutput("ovf_err", out_err, 1);
    checkOutput("ovf_tt", out_tt, 0);
`else
    checkOutput("ovf_err", out_err, 0);
    checkOutput("ovf_tt", out_tt, 32'h8888);
`endif
    takeResult("ovf");

    // Reset mid-program, then the full program must still evaluate from a clean count.
    applyStimulus(5'd0, 1, 5'd3, 0, 5'd4, 0, 0, 0);
    applyStimulus(5'd1, 1, 5'd2, 0, 5'd5, 0, 0, 0);
    applyStimulus(5'd1, 0, 5'd2, 0, 5'd5, 0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_ready_held", in_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready_rel", in_ready, 1);
    sixProgram("six_after_rst");

    rst = 1'b1;
    #1;
    checkOutput("donerst_valid", out_valid, 0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("donerst_ready", in_ready, 1);
    applyStimulus(5'd1, 0, 5'd2, 0, 5'd0, 0, 1, 0);
    checkOutput("donerst_tt", out_tt, 32'h8888);
    checkOutput("donerst_nodes", out_nodes, 1);
    takeResult("donerst");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
